fnd_bcd_scanner: RTL and testbench

//  Downstream display stage of the SPI slave path. Takes the 14-bit counter value
//  the slave reassembles from SPI frames (value + 1-cycle valid strobe) and converts
//  it to 4-digit BCD with a sequential double-dabble engine. Time-multiplexes the
//  4-digit common-anode FND on the board, with leading-zero blanking.

---
 rtl/fnd_bcd_scanner.sv | 164 ++++++++++++++++
 tb/tb_fnd_bcd_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_bcd_scanner.sv
// Display stage: 14-bit value -> 4-digit BCD via serial double-dabble,
// then multiplexed onto a 4-digit common-anode FND with zero blanking.
module fnd_bcd_scanner #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCAN_HZ     = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] i_value,
  input  logic        i_valid,
  output logic        o_busy,
  output logic [15:0] o_bcd,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_data
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [13:0] bin, bin_n;
  logic [15:0] bcd, bcd_n;
  logic [15:0] bcd_out_n;
  logic [3:0]  cnt, cnt_n;
  logic        pend, pend_n;
  logic [13:0] pval, pval_n;
  logic [29:0] shifted;

  function automatic logic [13:0] sat(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      pend  <= 1'b0;
      pval  <= '0;
      o_bcd <= '0;
    end else begin
      state <= state_n;
      bin   <= bin_n;
      bcd   <= bcd_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      pval  <= pval_n;
      o_bcd <= bcd_out_n;
    end
  end

  assign shifted = {adj(bcd[15:12]), adj(bcd[11:8]),
                    adj(bcd[7:4]), adj(bcd[3:0]), bin} << 1;

  always_comb begin
    state_n   = state;
    bin_n     = bin;
    bcd_n     = bcd;
    cnt_n     = cnt;
    pend_n    = pend;
    pval_n    = pval;
    bcd_out_n = o_bcd;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          bin_n   = sat(i_value);
          bcd_n   = '0;
          cnt_n   = '0;
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_n, bin_n} = shifted;
        cnt_n = cnt + 4'd1;
        if (cnt == 4'd13) state_n = DONE;
        if (i_valid) begin
          pend_n = 1'b1;
          pval_n = sat(i_value);
        end
      end
      DONE: begin
        bcd_out_n = bcd;
        // A strobe landing in DONE wins over an older pending value
        if (i_valid || pend) begin
          bin_n   = i_valid ? sat(i_value) : pval;
          bcd_n   = '0;
          cnt_n   = '0;
          pend_n  = 1'b0;
          state_n = CONVERT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [3:0]    blank;
  logic [3:0]    digit;
  logic [7:0]    seg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else if (div == DW'(DIV - 1)) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign blank[3] = (o_bcd[15:12] == 4'd0);
  assign blank[2] = blank[3] && (o_bcd[11:8] == 4'd0);
  assign blank[1] = blank[2] && (o_bcd[7:4] == 4'd0);
  assign blank[0] = 1'b0;
  assign digit    = o_bcd[{idx, 2'b00} +: 4];

  always_comb begin
    seg = 8'hFF;
    if (!blank[idx]) begin
      unique case (digit)
        4'd0: seg = 8'hC0;
        4'd1: seg = 8'hF9;
        4'd2: seg = 8'hA4;
        4'd3: seg = 8'hB0;
        4'd4: seg = 8'h99;
        4'd5: seg = 8'h92;
        4'd6: seg = 8'h82;
        4'd7: seg = 8'hF8;
        4'd8: seg = 8'h80;
        4'd9: seg = 8'h90;
        default: seg = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_com  <= 4'b1110;
      fnd_data <= 8'hC0;
    end else begin
      fnd_com  <= ~(4'b0001 << idx);
      fnd_data <= seg;
    end
  end

endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// Scoreboard bench for fnd_bcd_scanner at 10 cycles per digit.
module tb_fnd_bcd_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] i_value;
  logic        i_valid;
  logic        o_busy;
  logic [15:0] o_bcd;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  fnd_bcd_scanner #(
    .CLK_FREQ_HZ(1000),
    .SCAN_HZ    (100)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_value (i_value),
    .i_valid (i_valid),
    .o_busy  (o_busy),
    .o_bcd   (o_bcd),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] tab [10];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tab[d];
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    return seg_of((v / p) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  logic bchk = 1'b0;
  int   blo  = 0;
  int   bhi  = -1;
  logic dchk = 1'b0;
  int   dval = 0;
  logic [3:0] seen;
  int   mk;

  always @(negedge clk) begin
    if (q.size() > 0 && cyc >= q[0].due) begin
      check($sformatf("o_bcd@%0d", q[0].due), o_bcd, q[0].v);
      void'(q.pop_front());
    end
    if (bchk) check("o_busy", o_busy, (cyc >= blo && cyc <= bhi));
    if (dchk) begin
      case (fnd_com)
        4'b1110: mk = 0;
        4'b1101: mk = 1;
        4'b1011: mk = 2;
        4'b0111: mk = 3;
        default: mk = -1;
      endcase
      if (mk < 0) check("fnd_com_onehot", fnd_com, 4'b1110);
      else begin
        check($sformatf("seg_d%0d", mk), fnd_data, exp_seg(dval, mk));
        seen[mk] = 1'b1;
      end
    end
  end

  task automatic pulse(input logic [13:0] v, output int e);
    i_value = v;
    i_valid = 1'b1;
    e = cyc + 1;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 80) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic show(input int v);
    repeat (2) @(posedge clk);
    #1;
    dval = v;
    seen = '0;
    dchk = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    dchk = 1'b0;
    check("scan_all", seen, 4'hF);
  endtask

  task automatic convert(input int v, input int shown, input logic [15:0] old);
    int e;
    blo  = cyc + 1;
    bhi  = cyc + 15;
    bchk = 1'b1;
    pulse(14'(v), e);
    q.push_back('{e + 14, old});
    q.push_back('{e + 15, to_bcd(shown)});
    drain();
    show(shown);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e, x, h;
    logic [3:0] prev;
    logic [3:0] seqv [5];
    reset   = 1'b1;
    i_valid = 1'b0;
    i_value = '0;
    #2;
    check("rst_busy", o_busy, 0);
    check("rst_bcd", o_bcd, 16'h0000);
    check("rst_com", fnd_com, 4'b1110);
    check("rst_data", fnd_data, 8'hC0);
    @(posedge clk); #1;
    reset = 1'b0;

    // scan wrap and per-digit hold time
    seqv = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    prev = fnd_com;
    h = 0;
    while (fnd_com == prev && h < 30) begin
      @(posedge clk); #1;
      h++;
    end
    for (int i = 0; i < 4; i++) begin
      check("com_seq", fnd_com, seqv[i]);
      prev = fnd_com;
      h = 0;
      while (fnd_com == prev && h < 30) begin
        @(posedge clk); #1;
        h++;
      end
      check("com_hold", h, 10);
    end
    check("com_wrap", fnd_com, seqv[4]);

    convert(1234, 1234, 16'h0000);
    convert(16383, 9999, 16'h1234);
    convert(7, 7, 16'h9999);
    convert(0, 0, 16'h0007);

    // back-to-back: 200 is overwritten by 300 while 100 converts
    blo  = cyc + 1;
    bhi  = cyc + 30;
    bchk = 1'b1;
    pulse(14'd100, e);
    q.push_back('{e + 14, 16'h0000});
    q.push_back('{e + 15, 16'h0100});
    q.push_back('{e + 29, 16'h0100});
    q.push_back('{e + 30, 16'h0300});
    wait_until(e + 2);
    pulse(14'd200, x);
    wait_until(e + 4);
    pulse(14'd300, x);
    drain();
    show(300);

    // reset in the middle of a conversion
    bchk = 1'b0;
    pulse(14'd4321, e);
    wait_until(e + 6);
    reset = 1'b1;
    #1;
    check("mid_busy", o_busy, 0);
    check("mid_bcd", o_bcd, 16'h0000);
    check("mid_com", fnd_com, 4'b1110);
    check("mid_data", fnd_data, 8'hC0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.push_back('{e + 16, 16'h0000});
    drain();
    convert(55, 55, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
